// File: rtl/sdram_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : sdram_byte_packer
// Description : Packs byte pairs from the counter into 16-bit words, buffers
//               them in a small FIFO and issues sequential SDRAM writes.
// Revision    : 1.0 - initial release
// ============================================================================
module sdram_byte_packer #(
   parameter int                ADDR_W    = 8,
   parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
   parameter int                NUM_WORDS = 16,
   parameter int                DEPTH     = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [15:0]       wr_data,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_req,
   input  logic              wr_ack,
   output logic              done,
   output logic              busy
);

   localparam int CNT_W = $clog2(NUM_WORDS + 1);
   localparam int PTR_W = $clog2(DEPTH);
   localparam int LVL_W = $clog2(DEPTH + 1);

   localparam logic [CNT_W-1:0] c_num_words = CNT_W'(NUM_WORDS);
   localparam logic [CNT_W-1:0] c_last_word = CNT_W'(NUM_WORDS - 1);
   localparam logic [LVL_W-1:0] c_depth     = LVL_W'(DEPTH);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RUN  = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t            r_state;
   state_t            w_state_nxt;
   logic              w_enter_run;

   logic [15:0]       r_mem [DEPTH];
   logic [PTR_W-1:0]  r_wptr;
   logic [PTR_W-1:0]  r_rptr;
   logic [LVL_W-1:0]  r_count;
   logic              r_phase;
   logic [7:0]        r_low;
   logic [CNT_W-1:0]  r_packed;
   logic [CNT_W-1:0]  r_written;
   logic [ADDR_W-1:0] r_addr;

   logic              w_accept;
   logic              w_push;
   logic              w_pop;

   assign wr_req   = (r_count != '0);
   assign wr_addr  = r_addr;
   // Head is masked when empty so the write bus idles at zero.
   assign wr_data  = wr_req ? r_mem[r_rptr] : 16'h0000;

   assign w_accept = in_valid && in_ready;
   assign w_push   = w_accept && r_phase;
   assign w_pop    = wr_req && wr_ack;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_enter_run = 1'b0;
      busy        = (r_state == S_RUN);
      done        = (r_state == S_DONE);
      // No pass-through when full: a same-cycle pop never opens the input.
      in_ready    = (r_state == S_RUN) && (r_count < c_depth) &&
                    (r_packed < c_num_words);
      case (r_state)
         S_IDLE, S_DONE: begin
            if (start) begin
               w_state_nxt = S_RUN;
               w_enter_run = 1'b1;
            end
         end
         S_RUN: begin
            if (w_pop && (r_written == c_last_word)) begin
               w_state_nxt = S_DONE;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (w_push) begin
         r_mem[r_wptr] <= {in_data, r_low};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_phase   <= 1'b0;
         r_low     <= 8'h00;
         r_packed  <= '0;
         r_written <= '0;
         r_addr    <= BASE_ADDR;
      end else if (w_enter_run) begin
         r_wptr    <= '0;
         r_rptr    <= '0;
         r_count   <= '0;
         r_phase   <= 1'b0;
         r_packed  <= '0;
         r_written <= '0;
         r_addr    <= BASE_ADDR;
      end else begin
         if (w_accept) begin
            r_phase <= ~r_phase;
            if (!r_phase) begin
               r_low <= in_data;
            end
         end
         if (w_push) begin
            r_wptr   <= r_wptr + PTR_W'(1);
            r_packed <= r_packed + CNT_W'(1);
         end
         if (w_pop) begin
            r_rptr    <= r_rptr + PTR_W'(1);
            r_written <= r_written + CNT_W'(1);
            r_addr    <= r_addr + ADDR_W'(1);
         end
         case ({w_push, w_pop})
            2'b10:   r_count <= r_count + LVL_W'(1);
            2'b01:   r_count <= r_count - LVL_W'(1);
            default: r_count <= r_count;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_sdram_byte_packer.sv
`default_nettype none
// ============================================================================
// Module      : tb_sdram_byte_packer
// Description : Vector table plus directed burst sequences for the packer.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sdram_byte_packer;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       reset;
   logic       a_st, a_vld, a_ack, a_rdy, a_wreq, a_dn, a_bsy;
   logic [7:0] a_dat, a_wadr;
   logic [15:0] a_wdat;
   logic       b_st, b_vld, b_ack, b_rdy, b_wreq, b_dn, b_bsy;
   logic [7:0] b_dat, b_wadr;
   logic [15:0] b_wdat;

   logic       sel;
   logic       m_rdy, m_wreq, m_dn, m_bsy;
   logic [7:0] m_wadr;
   logic [15:0] m_wdat;

   assign m_rdy  = sel ? b_rdy  : a_rdy;
   assign m_wreq = sel ? b_wreq : a_wreq;
   assign m_dn   = sel ? b_dn   : a_dn;
   assign m_bsy  = sel ? b_bsy  : a_bsy;
   assign m_wadr = sel ? b_wadr : a_wadr;
   assign m_wdat = sel ? b_wdat : a_wdat;

   sdram_byte_packer u_dut_a (
      .clk(clk), .reset(reset), .start(a_st), .in_data(a_dat),
      .in_valid(a_vld), .in_ready(a_rdy), .wr_data(a_wdat), .wr_addr(a_wadr),
      .wr_req(a_wreq), .wr_ack(a_ack), .done(a_dn), .busy(a_bsy)
   );

   sdram_byte_packer #(.ADDR_W(8), .BASE_ADDR(8'hFE), .NUM_WORDS(4), .DEPTH(4)) u_dut_b (
      .clk(clk), .reset(reset), .start(b_st), .in_data(b_dat),
      .in_valid(b_vld), .in_ready(b_rdy), .wr_data(b_wdat), .wr_addr(b_wadr),
      .wr_req(b_wreq), .wr_ack(b_ack), .done(b_dn), .busy(b_bsy)
   );

   int         n_checks = 0;
   int         n_fail   = 0;
   logic [7:0] cur_byte;
   int         bytes_acc;
   int         wr_idx;
   logic [7:0] exp_base;
   logic [7:0] exp_abase;

   typedef struct {
      logic       st;
      logic       vld;
      logic [7:0] dat;
      logic       ack;
      logic       rdy;
      logic       wreq;
      logic [15:0] wdat;
      logic [7:0] wadr;
      logic       dn;
      logic       bsy;
   } vec_t;

   vec_t vecs [10];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic drive(input logic s, input logic stv, input logic vv,
                        input logic [7:0] d, input logic av);
      sel   = s;
      a_st  = s ? 1'b0 : stv;  b_st  = s ? stv : 1'b0;
      a_vld = s ? 1'b0 : vv;   b_vld = s ? vv  : 1'b0;
      a_dat = s ? 8'h00 : d;   b_dat = s ? d   : 8'h00;
      a_ack = s ? 1'b0 : av;   b_ack = s ? av  : 1'b0;
   endtask

   task automatic check_write();
      logic [7:0] lo, hi, ea;
      lo = exp_base + 8'(2 * wr_idx);
      hi = lo + 8'd1;
      ea = exp_abase + 8'(wr_idx);
      check($sformatf("wr_data[%0d]", wr_idx), 32'(m_wdat), {16'h0, hi, lo});
      check($sformatf("wr_addr[%0d]", wr_idx), 32'(m_wadr), 32'(ea));
      wr_idx++;
   endtask

   // One clock: drive at the falling edge, observe, then advance the counter.
   task automatic step(input logic s, input logic stv, input logic vv, input logic av);
      logic acc;
      @(negedge clk);
      drive(s, stv, vv, cur_byte, av);
      #1;
      acc = vv && m_rdy;
      if (m_wreq && av) check_write();
      @(posedge clk);
      if (acc) begin
         cur_byte++;
         bytes_acc++;
      end
   endtask

   task automatic run_until(input logic s, input int byte_lim, input logic av, input int target);
      int n;
      n = 0;
      while (wr_idx < target && n < 400) begin
         step(s, 1'b0, (bytes_acc < byte_lim), av);
         n++;
      end
      check("burst_progress", 32'(wr_idx), 32'(target));
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      cur_byte  = 8'h00;
      bytes_acc = 0;
      wr_idx    = 0;
      exp_base  = 8'h00;
      exp_abase = 8'h00;
   endtask

   initial begin
      #1ms;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      // st vld dat ack | rdy wreq wdat wadr dn bsy
      vecs[0] = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      vecs[1] = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      vecs[2] = '{1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b0};
      vecs[3] = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h00, 1'b0, 1'b1};
      vecs[5] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h55AA, 8'h00, 1'b0, 1'b1};
      vecs[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 16'h55AA, 8'h00, 1'b0, 1'b1};
      vecs[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 16'h55AA, 8'h00, 1'b0, 1'b1};
      vecs[8] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 16'h0000, 8'h01, 1'b0, 1'b1};
      vecs[9] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 16'h0000, 8'h01, 1'b0, 1'b1};

      reset = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
      repeat (2) @(posedge clk);
      do_reset();

      // Reset values on both instances.
      check("reset_outputs_a", {4'h0, a_rdy, a_wreq, a_wdat, a_wadr, a_dn, a_bsy}, 32'h0);
      check("reset_addr_b", 32'(b_wadr), 32'h0000_00FE);

      // Ignored inputs in IDLE, start, byte-pair latency, ack on empty FIFO.
      for (int i = 0; i < 10; i++) begin
         @(negedge clk);
         drive(1'b0, vecs[i].st, vecs[i].vld, vecs[i].dat, vecs[i].ack);
         #1;
         check($sformatf("vec%0d", i),
               {4'h0, m_rdy, m_wreq, m_wdat, m_wadr, m_dn, m_bsy},
               {4'h0, vecs[i].rdy, vecs[i].wreq, vecs[i].wdat, vecs[i].wadr,
                vecs[i].dn, vecs[i].bsy});
      end

      // Nominal burst with free-flowing writes.
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run_until(1'b0, 1000, 1'b1, 16);
      @(negedge clk);
      #1;
      check("nominal_done", {31'h0, m_dn}, 32'h1);
      check("nominal_busy", {31'h0, m_bsy}, 32'h0);
      check("nominal_in_ready", {31'h0, m_rdy}, 32'h0);
      check("nominal_bytes", 32'(bytes_acc), 32'd32);

      // Inputs ignored in DONE.
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
      check("done_bytes", 32'(bytes_acc), 32'd32);
      check("done_writes", 32'(wr_idx), 32'd16);
      check("done_addr", 32'(m_wadr), 32'h10);
      check("done_held", {31'h0, m_dn}, 32'h1);

      // Backpressure: FIFO fills, head holds, then drains in order.
      do_reset();
      step(1'b0, 1'b1, 1'b1, 1'b0);
      repeat (20) step(1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clk);
      #1;
      check("bp_bytes", 32'(bytes_acc), 32'd8);
      check("bp_in_ready", {31'h0, m_rdy}, 32'h0);
      check("bp_head", {15'h0, m_wreq, m_wdat}, 32'h0001_0100);
      check("bp_addr", 32'(m_wadr), 32'h0);
      run_until(1'b0, 1000, 1'b1, 16);
      check("bp_total_bytes", 32'(bytes_acc), 32'd32);

      // Reset mid-burst: 3 words written, one low byte pending.
      do_reset();
      step(1'b0, 1'b1, 1'b0, 1'b1);
      run_until(1'b0, 7, 1'b1, 3);
      check("mid_bytes", 32'(bytes_acc), 32'd7);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("mid_reset_outputs", {4'h0, m_rdy, m_wreq, m_wdat, m_wadr, m_dn, m_bsy}, 32'h0);
      repeat (3) step(1'b0, 1'b0, 1'b1, 1'b1);
      check("mid_no_writes", 32'(wr_idx), 32'd3);
      check("mid_no_bytes", 32'(bytes_acc), 32'd7);
      wr_idx   = 0;
      exp_base = cur_byte;
      step(1'b0, 1'b1, 1'b1, 1'b1);
      run_until(1'b0, 1000, 1'b1, 16);

      // Address wrap, start ignored during RUN, restart from DONE.
      do_reset();
      exp_abase = 8'hFE;
      step(1'b1, 1'b1, 1'b1, 1'b1);
      run_until(1'b1, 1000, 1'b1, 2);
      step(1'b1, 1'b1, 1'b1, 1'b1);
      run_until(1'b1, 1000, 1'b1, 4);
      @(negedge clk);
      #1;
      check("wrap_done", {30'h0, m_dn, m_bsy}, 32'h2);
      check("wrap_bytes", 32'(bytes_acc), 32'd8);
      check("wrap_addr_end", 32'(m_wadr), 32'h02);
      wr_idx   = 0;
      exp_base = cur_byte;
      step(1'b1, 1'b1, 1'b1, 1'b1);
      run_until(1'b1, 1000, 1'b1, 4);
      @(negedge clk);
      #1;
      check("restart_done", {30'h0, m_dn, m_bsy}, 32'h2);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/sdram_byte_packer.md
Name: sdram_byte_packer

Overview:
- Sits directly downstream of the 8-bit free-running counter.
- Takes the counter's byte stream, packs consecutive byte pairs into 16-bit words and buffers them in a small FIFO.
- Issues the words as sequential write requests to the SDRAM controller, one address per word.
- Runs one burst of NUM_WORDS words per start pulse, then reports done.

Parameters:
- ADDR_W, 8, width of the SDRAM word address.
- BASE_ADDR, 0, address of the first word of each burst.
- NUM_WORDS, 16, words per burst; legal range 1..2^ADDR_W.
- DEPTH, 4, FIFO depth in words; power of two, at least 2.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse that begins a burst.
- in_data  in  8  byte from the counter (its out value).
- in_valid  in  1  in_data is valid this cycle.
- in_ready  out  1  a byte is accepted on a cycle where in_valid and in_ready are both 1.
- wr_data  out  16  word at the FIFO head.
- wr_addr  out  ADDR_W  SDRAM word address for wr_data.
- wr_req  out  1  a write is pending.
- wr_ack  in  1  the controller accepts the write on a cycle where wr_req and wr_ack are both 1.
- done  out  1  burst complete; held high until the next start.
- busy  out  1  high while in RUN.

Behaviour:
- Reset, and clk/reset convention: one clock; reset is synchronous and active-high, on ports named clk and reset.
  - Values after reset: state=IDLE, in_ready=0, wr_req=0, wr_data=0, wr_addr=BASE_ADDR, done=0, busy=0.
  - FIFO is emptied, the pending low byte is discarded, all counters are cleared.
  - Reset asserted mid-burst aborts the burst; no further wr_req appears until the next start.
- States: IDLE, RUN, DONE.
  - IDLE to RUN on start. DONE to RUN on start. start in RUN is ignored.
  - RUN to DONE on the cycle the NUM_WORDS-th write is accepted. done goes high the following cycle and busy goes low.
  - Entering RUN clears the packed-word count, the written-word count and the byte phase; wr_addr loads BASE_ADDR; done clears.
- Input side:
  - in_ready = (state==RUN) && (fifo_count < DEPTH) && (packed < NUM_WORDS). It is combinational from registered state only, never from in_valid.
  - Byte phase 0: the accepted byte is latched as the low byte, then phase goes to 1.
  - Byte phase 1: the accepted byte becomes the high byte. The word {high, low} is pushed into the FIFO on that clock edge, packed increments, and phase returns to 0.
  - No partial-word output: a low byte still pending when the burst or reset ends is dropped.
- Full boundary:
  - When fifo_count == DEPTH, in_ready=0, even if a pop occurs in the same cycle. There is no pass-through when full.
  - A push and a pop in the same cycle while not full leaves the count unchanged.
- Output side:
  - wr_req = FIFO not empty. wr_data = FIFO head. Both come from registers.
  - Latency: the word appears on wr_data with wr_req=1 on the cycle after its high byte is accepted, provided the FIFO was empty.
  - wr_data and wr_addr are held stable while wr_req=1 and wr_ack=0.
  - On an accepted write: pop the FIFO, wr_addr increments by 1 and wraps modulo 2^ADDR_W, the written count increments.
  - wr_ack while wr_req=0 is ignored.
- Arithmetic:
  - Counters are wide enough to hold NUM_WORDS without overflow.
  - FIFO pointers wrap modulo DEPTH.

Test Plan:
- Nominal burst:
  - Stimulus: counter drives bytes 0x00,0x01,… with in_valid=1, wr_ack=1, pulse start.
  - Required: writes (addr,data) = (0x00,0x0100), (0x01,0x0302) … (0x0F,0x1F1E). in_ready drops after 32 bytes. done=1 one cycle after the 16th ack, busy=0.
- Backpressure:
  - Stimulus: wr_ack=0 for 20 cycles after start.
  - Required: FIFO fills to 4 words (0x0100..0x0706). in_ready=0 while full. wr_data holds 0x0100 at addr 0x00. Releasing wr_ack drains the FIFO in order with no loss or duplication.
- Latency check:
  - Stimulus: a single byte pair 0xAA then 0x55 into an empty FIFO.
  - Required: wr_req=1 and wr_data=0x55AA exactly one cycle after 0x55 is accepted.
- Reset mid-burst:
  - Stimulus: assert reset for 1 cycle after 3 words are written and 1 low byte is pending.
  - Required: all outputs at reset values next cycle. A new start writes from addr 0x00 with a fresh low byte.
- Wrap and restart:
  - Stimulus: BASE_ADDR=0xFE, NUM_WORDS=4.
  - Required: addresses 0xFE, 0xFF, 0x00, 0x01. A second start from DONE restarts at 0xFE. A start pulse during RUN has no effect.
- Ignored inputs:
  - Stimulus: in_valid=1 in IDLE and DONE; wr_ack=1 with an empty FIFO.
  - Required: in_ready=0, no words packed, and wr_addr unchanged.
